multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl_pkg.sv | 63 ++++++
 rtl/multi_cycle_ctrl_next_state.sv | 41 ++++
 rtl/multi_cycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - shared state, opcode and ALU-op definitions for the multi-cycle controller
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_HALT     = 4'd13
  } ctrl_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_LUI  = 3'b110;

  // True for the immediate-ALU opcodes handled by EXEC_I.
  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_SLTI) || (op == OP_LUI);
  endfunction

  // ALU operation selected by an immediate-ALU opcode.
  function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

  // Logical immediates and lui take a zero-extended immediate.
  function automatic logic itype_sign_ext(input logic [5:0] op);
    return !((op == OP_ANDI) || (op == OP_ORI) || (op == OP_LUI));
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_next_state.sv
// rtl/multi_cycle_ctrl_next_state.sv - combinational next-state decode for the multi-cycle controller
module mc_next_state
  import multi_cycle_ctrl_pkg::*;
(
  input  ctrl_state_e state_i,
  input  logic [5:0]  opcode_i,
  input  logic        mem_ready_i,
  output ctrl_state_e state_d_o
);

  // Next-state selection; memory states hold until the access completes.
  always_comb begin
    state_d_o = state_i;
    case (state_i)
      S_FETCH:    state_d_o = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode_i == OP_RTYPE)                          state_d_o = S_EXEC_R;
        else if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) state_d_o = S_MEM_ADDR;
        else if (opcode_i == OP_BEQ)                       state_d_o = S_BRANCH;
        else if (opcode_i == OP_J)                         state_d_o = S_JUMP;
        else if (opcode_i == OP_JAL)                       state_d_o = S_JAL;
        else if (is_itype(opcode_i))                       state_d_o = S_EXEC_I;
        else                                               state_d_o = S_HALT;
      end
      S_MEM_ADDR: state_d_o = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d_o = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d_o = S_FETCH;
      S_MEM_WR:   state_d_o = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_d_o = S_R_WB;
      S_R_WB:     state_d_o = S_FETCH;
      S_EXEC_I:   state_d_o = S_I_WB;
      S_I_WB:     state_d_o = S_FETCH;
      S_BRANCH:   state_d_o = S_FETCH;
      S_JUMP:     state_d_o = S_FETCH;
      S_JAL:      state_d_o = S_FETCH;
      S_HALT:     state_d_o = S_HALT;
      default:    state_d_o = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle datapath controller with Moore output decode
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       imm_ext_mode,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;

  // Branch qualification by zero happens in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  mc_next_state u_next_state (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .state_d_o   (state_d)
  );

  // State register; reset forces FETCH immediately, even mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Output decode from state; only FETCH commit and MEM_WR completion look at mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    imm_ext_mode  = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        // Commit only out of reset so the reset-time outputs stay quiet.
        pc_write  = mem_ready && rst_n;
        ir_write  = mem_ready && rst_n;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
      end
      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'd2;
        imm_ext_mode = 1'b1;
      end
      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 2'd1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNC;
      end
      S_R_WB: begin
        reg_dst    = 2'd1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'd2;
        alu_op       = itype_alu_op(opcode);
        imm_ext_mode = itype_sign_ext(opcode);
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2,
                         ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WR = 4'd5,
                         ST_EXEC_R = 4'd6, ST_R_WB = 4'd7, ST_EXEC_I = 4'd8,
                         ST_I_WB = 4'd9, ST_BRANCH = 4'd10, ST_JUMP = 4'd11,
                         ST_JAL = 4'd12, ST_HALT = 4'd13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_write, alu_src_a, imm_ext_mode, instr_done, halted;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .imm_ext_mode(imm_ext_mode), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .instr_done(instr_done), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a negedge with reset just released (FETCH, cycle 1).
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++; if (state !== ST_FETCH) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_FETCH); end
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL reset_mem_read got=%b exp=1", mem_read); end
    checks++; if ({pc_write, ir_write, reg_write, mem_write, pc_write_cond} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {pc_write, ir_write, reg_write, mem_write, pc_write_cond}); end
    checks++; if ({halted, instr_done} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {halted, instr_done}); end
  endtask

  task automatic test_rtype();
    logic [3:0] es [4] = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_R_WB};
    logic       ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    opcode = 6'b000000;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (state !== es[k]) begin failures++; $display("FAIL rtype_state cyc=%0d got=%0d exp=%0d", k + 1, state, es[k]); end
      checks++; if (reg_write !== ew[k]) begin failures++; $display("FAIL rtype_reg_write cyc=%0d got=%b exp=%b", k + 1, reg_write, ew[k]); end
      checks++; if (instr_done !== ew[k]) begin failures++; $display("FAIL rtype_instr_done cyc=%0d got=%b exp=%b", k + 1, instr_done, ew[k]); end
      if (k == 0) begin
        checks++; if ({pc_write, ir_write} !== 2'b11) begin failures++; $display("FAIL rtype_fetch_commit got=%b exp=11", {pc_write, ir_write}); end
      end
      if (k == 2) begin
        checks++; if ({alu_src_a, alu_src_b, alu_op} !== {1'b1, 2'd0, 3'b010}) begin failures++; $display("FAIL rtype_exec_sel got=%b exp=100010", {alu_src_a, alu_src_b, alu_op}); end
      end
      if (k == 3) begin
        checks++; if ({reg_dst, mem_to_reg} !== {2'd1, 2'd0}) begin failures++; $display("FAIL rtype_wb_sel got=%b exp=0100", {reg_dst, mem_to_reg}); end
      end
      step();
    end
    #1;
    checks++; if (state !== ST_FETCH) begin failures++; $display("FAIL rtype_return got=%0d exp=%0d", state, ST_FETCH); end
  endtask

  task automatic test_lw_stall();
    logic [3:0] es [7] = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD, ST_MEM_WB};
    logic       mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       erd [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int         wr_count = 0;
    do_reset();
    opcode = 6'b100011;
    for (int k = 0; k < 7; k++) begin
      mem_ready = mr[k];
      #1;
      checks++; if (state !== es[k]) begin failures++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", k + 1, state, es[k]); end
      checks++; if (mem_read !== erd[k]) begin failures++; $display("FAIL lw_mem_read cyc=%0d got=%b exp=%b", k + 1, mem_read, erd[k]); end
      if (reg_write === 1'b1) wr_count++;
      if (k == 2) begin
        checks++; if ({alu_src_a, alu_src_b, imm_ext_mode} !== 4'b1101) begin failures++; $display("FAIL lw_addr_sel got=%b exp=1101", {alu_src_a, alu_src_b, imm_ext_mode}); end
      end
      if (k == 6) begin
        checks++; if ({reg_write, mem_to_reg, reg_dst, instr_done} !== {1'b1, 2'd1, 2'd0, 1'b1}) begin failures++; $display("FAIL lw_wb got=%b exp=101001", {reg_write, mem_to_reg, reg_dst, instr_done}); end
      end
      step();
    end
    #1;
    checks++; if (wr_count !== 1) begin failures++; $display("FAIL lw_reg_write_count got=%0d exp=1", wr_count); end
    checks++; if (state !== ST_FETCH) begin failures++; $display("FAIL lw_return got=%0d exp=%0d", state, ST_FETCH); end
  endtask

  task automatic test_sw();
    logic [3:0] es [4] = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR};
    do_reset();
    opcode = 6'b101011;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (state !== es[k]) begin failures++; $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", k + 1, state, es[k]); end
      if (k == 3) begin
        checks++; if ({mem_write, mem_read, i_or_d, instr_done} !== 4'b1011) begin failures++; $display("FAIL sw_wr got=%b exp=1011", {mem_write, mem_read, i_or_d, instr_done}); end
      end
      step();
    end
    #1;
    checks++; if (state !== ST_FETCH) begin failures++; $display("FAIL sw_return got=%0d exp=%0d", state, ST_FETCH); end
  endtask

  task automatic test_beq();
    logic [3:0] es [3] = '{ST_FETCH, ST_DECODE, ST_BRANCH};
    logic       ec [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] eps [3] = '{2'd0, 2'd0, 2'd1};
    do_reset();
    opcode = 6'b000100;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (state !== es[k]) begin failures++; $display("FAIL beq_state cyc=%0d got=%0d exp=%0d", k + 1, state, es[k]); end
      checks++; if (pc_write_cond !== ec[k]) begin failures++; $display("FAIL beq_pc_write_cond cyc=%0d got=%b exp=%b", k + 1, pc_write_cond, ec[k]); end
      checks++; if (pc_source !== eps[k]) begin failures++; $display("FAIL beq_pc_source cyc=%0d got=%0d exp=%0d", k + 1, pc_source, eps[k]); end
      if (k == 2) begin
        checks++; if ({alu_op, instr_done} !== {3'b001, 1'b1}) begin failures++; $display("FAIL beq_alu_done got=%b exp=0011", {alu_op, instr_done}); end
      end
      step();
    end
    #1;
    checks++; if (state !== ST_FETCH) begin failures++; $display("FAIL beq_return got=%0d exp=%0d", state, ST_FETCH); end
  endtask

  task automatic test_jal();
    do_reset();
    opcode = 6'b000011;
    mem_ready = 1'b1;
    step();
    step();
    #1;
    checks++; if (state !== ST_JAL) begin failures++; $display("FAIL jal_state got=%0d exp=%0d", state, ST_JAL); end
    checks++; if ({pc_write, reg_dst, mem_to_reg, reg_write, pc_source, instr_done} !== {1'b1, 2'd2, 2'd2, 1'b1, 2'd2, 1'b1}) begin
      failures++; $display("FAIL jal_outputs got=%b exp=110101101", {pc_write, reg_dst, mem_to_reg, reg_write, pc_source, instr_done});
    end
    step();
    #1;
    checks++; if (state !== ST_FETCH) begin failures++; $display("FAIL jal_return got=%0d exp=%0d", state, ST_FETCH); end
  endtask

  task automatic test_jump_fetch_stall();
    logic [3:0] es [4] = '{ST_FETCH, ST_FETCH, ST_DECODE, ST_JUMP};
    logic       mr [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       epw [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    opcode = 6'b000010;
    for (int k = 0; k < 4; k++) begin
      mem_ready = mr[k];
      #1;
      checks++; if (state !== es[k]) begin failures++; $display("FAIL jump_state cyc=%0d got=%0d exp=%0d", k + 1, state, es[k]); end
      checks++; if (pc_write !== epw[k]) begin failures++; $display("FAIL jump_pc_write cyc=%0d got=%b exp=%b", k + 1, pc_write, epw[k]); end
      if (k == 3) begin
        checks++; if ({pc_source, reg_write, instr_done} !== 4'b1001) begin failures++; $display("FAIL jump_outputs got=%b exp=1001", {pc_source, reg_write, instr_done}); end
      end
      step();
    end
  endtask

  task automatic test_itype();
    logic [5:0] ops [3] = '{6'b001101, 6'b001111, 6'b001000};
    logic [2:0] eop [3] = '{3'b011, 3'b110, 3'b000};
    logic       eext [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      opcode = ops[i];
      mem_ready = 1'b1;
      step();
      step();
      #1;
      checks++; if (state !== ST_EXEC_I) begin failures++; $display("FAIL itype_exec_state op=%b got=%0d exp=%0d", ops[i], state, ST_EXEC_I); end
      checks++; if ({alu_op, imm_ext_mode, alu_src_b} !== {eop[i], eext[i], 2'd2}) begin
        failures++; $display("FAIL itype_exec op=%b got=%b exp=%b", ops[i], {alu_op, imm_ext_mode, alu_src_b}, {eop[i], eext[i], 2'd2});
      end
      step();
      #1;
      checks++; if ({state, reg_write, reg_dst, mem_to_reg, instr_done} !== {ST_I_WB, 1'b1, 2'd0, 2'd0, 1'b1}) begin
        failures++; $display("FAIL itype_wb op=%b got=%b", ops[i], {state, reg_write, reg_dst, mem_to_reg, instr_done});
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    opcode = 6'b111111;
    mem_ready = 1'b1;
    step();
    step();
    for (int k = 0; k < 20; k++) begin
      #1;
      checks++; if ({state, halted, mem_read, pc_write, instr_done} !== {ST_HALT, 4'b1000}) begin
        failures++; $display("FAIL halt_hold cyc=%0d got=%b", k, {state, halted, mem_read, pc_write, instr_done});
      end
      step();
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({state, halted, mem_read} !== {ST_FETCH, 2'b01}) begin failures++; $display("FAIL halt_reset_exit got=%b", {state, halted, mem_read}); end
    step();
    rst_n = 1'b1;
    opcode = 6'b000000;
    step();
    #1;
    checks++; if (state !== ST_DECODE) begin failures++; $display("FAIL halt_refetch got=%0d exp=%0d", state, ST_DECODE); end
  endtask

  task automatic test_reset_mid_wr();
    do_reset();
    opcode = 6'b101011;
    mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if ({state, mem_write, instr_done} !== {ST_MEM_WR, 2'b10}) begin failures++; $display("FAIL wr_stall got=%b", {state, mem_write, instr_done}); end
    step();
    #1;
    checks++; if ({state, mem_write} !== {ST_MEM_WR, 1'b1}) begin failures++; $display("FAIL wr_stall_hold got=%b", {state, mem_write}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({state, mem_write, mem_read} !== {ST_FETCH, 2'b01}) begin failures++; $display("FAIL wr_async_reset got=%b", {state, mem_write, mem_read}); end
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_beq();
    test_jal();
    test_jump_fetch_stall();
    test_itype();
    test_halt();
    test_reset_mid_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
